decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage_pkg.sv | 36 +++
 rtl/decode_stage_imm_extend.sv | 18 +
 rtl/decode_stage.sv | 102 ++++++++++
 tb/tb_decode_stage.sv | 125 ++++++++++++
 4 files changed

// File: rtl/decode_stage_pkg.sv
// decode_stage_pkg: opcode constants and control encodings shared by the decode stage
package decode_stage_pkg;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_IALU  = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [1:0] {IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11} immSrc_t;

    typedef enum logic [1:0] {RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10} resultSrc_t;

    typedef enum logic [1:0] {ALUOP_ADD = 2'b00, ALUOP_SUB = 2'b01, ALUOP_FUNCT = 2'b10, ALUOP_RSVD = 2'b11} aluOp_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_SLT = 3'b101
    } aluCtrl_t;

    typedef struct packed {
        logic       regWrite;
        immSrc_t    immSrc;
        logic       aluSrc;
        logic       memWrite;
        resultSrc_t resultSrc;
        logic       branch;
        aluOp_t     aluOp;
        logic       jump;
    } ctrl_t;

endpackage

// File: rtl/decode_stage_imm_extend.sv
// imm_extend: sign-extends the I/S/B/J immediate selected by immSrc
import decode_stage_pkg::*;

module imm_extend (
    input  logic [31:7] instr,
    input  immSrc_t     immSrc,
    output logic [31:0] immExt
);

    // pick the immediate layout; every format sign-extends from instr[31]
    always_comb begin
        immExt = immSrc == IMM_I ? {{20{instr[31]}}, instr[31:20]} :
                 immSrc == IMM_S ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                 immSrc == IMM_B ? {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0} :
                                   {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: main/ALU decoders, immediate extension and the ID/EX pipeline register
import decode_stage_pkg::*;

module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] PCD,
    input  logic [31:0] PCPlus4D,
    input  logic [31:0] RD1D,
    input  logic [31:0] RD2D,
    output logic        RegWriteD,
    output logic        RegWriteE,
    output logic        MemWriteE,
    output logic        JumpE,
    output logic        BranchE,
    output logic        ALUSrcE,
    output logic [1:0]  ResultSrcE,
    output logic [2:0]  ALUControlE,
    output logic [4:0]  RdE,
    output logic [31:0] PCE,
    output logic [31:0] RD1E,
    output logic [31:0] RD2E,
    output logic [31:0] ImmExtE,
    output logic [31:0] PCPlus4E
);

    ctrl_t       ctrlD;
    aluCtrl_t    aluCtrlD;
    logic [31:0] immExtD;

    // main decoder; unknown or X opcodes fall to the all-zero default so they never write
    always_comb begin
        ctrlD = '0;
        case (InstrD[6:0])
            OP_LW:    ctrlD = '{1'b1, IMM_I, 1'b1, 1'b0, RES_MEM, 1'b0, ALUOP_ADD,   1'b0};
            OP_SW:    ctrlD = '{1'b0, IMM_S, 1'b1, 1'b1, RES_ALU, 1'b0, ALUOP_ADD,   1'b0};
            OP_RTYPE: ctrlD = '{1'b1, IMM_I, 1'b0, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
            OP_BEQ:   ctrlD = '{1'b0, IMM_B, 1'b0, 1'b0, RES_ALU, 1'b1, ALUOP_SUB,   1'b0};
            OP_IALU:  ctrlD = '{1'b1, IMM_I, 1'b1, 1'b0, RES_ALU, 1'b0, ALUOP_FUNCT, 1'b0};
            OP_JAL:   ctrlD = '{1'b1, IMM_J, 1'b0, 1'b0, RES_PC4, 1'b0, ALUOP_ADD,   1'b1};
            default:  ctrlD = '0;
        endcase
    end

    // ALU decoder; sub needs both the R-type opcode bit and funct7[5] so addi never subtracts
    always_comb begin
        aluCtrlD = ALU_ADD;
        if (ctrlD.aluOp == ALUOP_SUB)
            aluCtrlD = ALU_SUB;
        else if (ctrlD.aluOp == ALUOP_FUNCT)
            case (InstrD[14:12])
                3'b000:  aluCtrlD = (InstrD[5] && InstrD[30]) ? ALU_SUB : ALU_ADD;
                3'b010:  aluCtrlD = ALU_SLT;
                3'b110:  aluCtrlD = ALU_OR;
                3'b111:  aluCtrlD = ALU_AND;
                default: aluCtrlD = ALU_ADD;
            endcase
    end

    assign RegWriteD = ctrlD.regWrite;

    imm_extend uImmExtend (
        .instr  (InstrD[31:7]),
        .immSrc (ctrlD.immSrc),
        .immExt (immExtD)
    );

    // ID/EX register: loads every cycle, cleared asynchronously by reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            RegWriteE   <= 1'b0;
            MemWriteE   <= 1'b0;
            JumpE       <= 1'b0;
            BranchE     <= 1'b0;
            ALUSrcE     <= 1'b0;
            ResultSrcE  <= '0;
            ALUControlE <= '0;
            RdE         <= '0;
            PCE         <= '0;
            RD1E        <= '0;
            RD2E        <= '0;
            ImmExtE     <= '0;
            PCPlus4E    <= '0;
        end else begin
            RegWriteE   <= ctrlD.regWrite;
            MemWriteE   <= ctrlD.memWrite;
            JumpE       <= ctrlD.jump;
            BranchE     <= ctrlD.branch;
            ALUSrcE     <= ctrlD.aluSrc;
            ResultSrcE  <= ctrlD.resultSrc;
            ALUControlE <= aluCtrlD;
            RdE         <= InstrD[11:7];
            PCE         <= PCD;
            RD1E        <= RD1D;
            RD2E        <= RD2D;
            ImmExtE     <= immExtD;
            PCPlus4E    <= PCPlus4D;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: table-driven check of decode_stage plus reset corner sequences
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] InstrD, PCD, PCPlus4D, RD1D, RD2D;
    logic        RegWriteD, RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
    logic [4:0]  RdE;
    logic [31:0] PCE, RD1E, RD2E, ImmExtE, PCPlus4E;

    decode_stage dut (
        .clk         (clk),
        .reset       (reset),
        .InstrD      (InstrD),
        .PCD         (PCD),
        .PCPlus4D    (PCPlus4D),
        .RD1D        (RD1D),
        .RD2D        (RD2D),
        .RegWriteD   (RegWriteD),
        .RegWriteE   (RegWriteE),
        .MemWriteE   (MemWriteE),
        .JumpE       (JumpE),
        .BranchE     (BranchE),
        .ALUSrcE     (ALUSrcE),
        .ResultSrcE  (ResultSrcE),
        .ALUControlE (ALUControlE),
        .RdE         (RdE),
        .PCE         (PCE),
        .RD1E        (RD1E),
        .RD2E        (RD2E),
        .ImmExtE     (ImmExtE),
        .PCPlus4E    (PCPlus4E)
    );

    always #5 clk = ~clk;

    logic [174:0] allE;
    assign allE = {RegWriteE, MemWriteE, JumpE, BranchE, ALUSrcE, ResultSrcE, ALUControlE, RdE,
                   PCE, RD1E, RD2E, ImmExtE, PCPlus4E};

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        rw, mw, j, b, as;
        logic [1:0]  rs;
        logic [2:0]  ac;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs[12];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] pc);
        InstrD   = instr;
        PCD      = pc;
        PCPlus4D = pc + 32'd4;
        RD1D     = pc ^ 32'hA5A5_0000;
        RD2D     = ~pc;
    endtask

    function automatic logic [174:0] expE(input vec_t v);
        return {v.rw, v.mw, v.j, v.b, v.as, v.rs, v.ac, v.rd,
                v.pc, v.pc ^ 32'hA5A5_0000, ~v.pc, v.imm, v.pc + 32'd4};
    endfunction

    initial begin
        vecs[0]  = '{32'hFFC4A303, 32'h040, 1, 0, 0, 0, 1, 2'b01, 3'b000, 5'd6,  32'hFFFFFFFC};
        vecs[1]  = '{32'h0064A423, 32'h044, 0, 1, 0, 0, 1, 2'b00, 3'b000, 5'd8,  32'h00000008};
        vecs[2]  = '{32'h0062E233, 32'h048, 1, 0, 0, 0, 0, 2'b00, 3'b011, 5'd4,  32'h00000006};
        vecs[3]  = '{32'h40B50533, 32'h04C, 1, 0, 0, 0, 0, 2'b00, 3'b001, 5'd10, 32'h0000040B};
        vecs[4]  = '{32'hFE420AE3, 32'h050, 0, 0, 0, 1, 0, 2'b00, 3'b001, 5'd21, 32'hFFFFFFF4};
        vecs[5]  = '{32'h008000EF, 32'h100, 1, 0, 1, 0, 0, 2'b10, 3'b000, 5'd1,  32'h00000008};
        vecs[6]  = '{32'hFFF00293, 32'h104, 1, 0, 0, 0, 1, 2'b00, 3'b000, 5'd5,  32'hFFFFFFFF};
        vecs[7]  = '{32'h0020A193, 32'h108, 1, 0, 0, 0, 1, 2'b00, 3'b101, 5'd3,  32'h00000002};
        vecs[8]  = '{32'h009473B3, 32'h10C, 1, 0, 0, 0, 0, 2'b00, 3'b010, 5'd7,  32'h00000009};
        vecs[9]  = '{32'hFFFFFFFF, 32'h110, 0, 0, 0, 0, 0, 2'b00, 3'b000, 5'd31, 32'hFFFFFFFF};
        vecs[10] = '{32'h00209133, 32'h114, 1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd2,  32'h00000002};
        vecs[11] = '{32'h00628233, 32'h118, 1, 0, 0, 0, 0, 2'b00, 3'b000, 5'd4,  32'h00000006};

        // async reset with arbitrary inputs, before any clock edge
        reset = 1'b0;
        drive(32'h0062E233, 32'h1234_5678);
        #2 reset = 1'b1;
        #1 chk("reset_async", allE, '0);
        @(posedge clk) #1 chk("reset_held_edge", allE, '0);
        @(negedge clk) reset = 1'b0;
        #1 chk("reset_release_no_edge", allE, '0);

        for (int i = 0; i < 12; i++) begin
            @(negedge clk) drive(vecs[i].instr, vecs[i].pc);
            #1 chk($sformatf("RegWriteD[%0d]", i), RegWriteD, vecs[i].rw);
            @(posedge clk) #1 chk($sformatf("E_regs[%0d]", i), allE, expE(vecs[i]));
        end

        // reset mid-operation: clear without an edge, in-flight lw discarded
        @(negedge clk) drive(vecs[0].instr, vecs[0].pc);
        #1 reset = 1'b1;
        #1 chk("reset_mid_async", allE, '0);
        @(posedge clk) #1 chk("reset_mid_discard", allE, '0);
        @(negedge clk) reset = 1'b0;
        #1 chk("reset_mid_release", allE, '0);
        @(posedge clk) #1 chk("reload_after_reset", allE, expE(vecs[0]));

        // X opcode must not enable writes
        @(negedge clk) InstrD = {25'h0, 7'bxxxxxxx};
        #1 chk("x_RegWriteD", RegWriteD, 1'b0);
        @(posedge clk) #1 chk("x_writesE", {RegWriteE, MemWriteE}, 2'b00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
